// File: rtl/wb_sram_slave.sv
// Wishbone B4 registered-feedback SRAM slave: classic cycles and CTI/BTE incrementing bursts.
// Define WB_SRAM_RANGE_ERR_EN to answer out-of-window beats with ERR instead of aliasing.
module wb_sram_slave #(
  parameter int unsigned              WB_ADDR_WIDTH = 32,
  parameter int unsigned              WB_DATA_WIDTH = 32,
  parameter int unsigned              MEM_ADDR_BITS = 10,
  parameter logic [WB_ADDR_WIDTH-1:0] BASE_ADDR     = '0
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [WB_ADDR_WIDTH-1:0]   s_adr,
  input  logic [2:0]                 s_cti,
  input  logic [1:0]                 s_bte,
  input  logic [WB_DATA_WIDTH-1:0]   s_dat_w,
  input  logic                       s_cyc,
  input  logic [WB_DATA_WIDTH/8-1:0] s_sel,
  input  logic                       s_stb,
  input  logic                       s_we,
  output logic [WB_DATA_WIDTH-1:0]   s_dat_r,
  output logic                       s_ack,
  output logic                       s_err
);

  localparam int unsigned NumBytes = WB_DATA_WIDTH / 8;
  localparam int unsigned Align    = $clog2(NumBytes);
  localparam int unsigned WordBits = WB_ADDR_WIDTH - Align;
  localparam int unsigned Depth    = 1 << MEM_ADDR_BITS;

  typedef enum logic [1:0] {StIdle, StClassic, StBurst} state_e;

  state_e                     state_q, state_d;
  logic [MEM_ADDR_BITS-1:0]   baddr_q, baddr_d, rd_addr;
  logic                       ack_q, ack_d, err_q, err_d;
  logic                       rd_en, req, beat_done, wr_en;
  logic                       cur_ok, nxt_ok;
  logic [WordBits-1:0]        baddr_ext, baddr_adv;
  logic [WB_DATA_WIDTH-1:0]   dat_r_q;
  logic [WB_DATA_WIDTH-1:0]   mem [Depth];
  logic                       unused_adr;

  // Next word address of a burst: linear, or wrap within a 4/8/16-word block.
  function automatic logic [WordBits-1:0] next_word(input logic [WordBits-1:0] w,
                                                    input logic [1:0]          bte);
    logic [WordBits-1:0] inc;
    inc       = w + WordBits'(1);
    next_word = inc;
    case (bte)
      2'b01:   next_word = {w[WordBits-1:2], inc[1:0]};
      2'b10:   next_word = {w[WordBits-1:3], inc[2:0]};
      2'b11:   next_word = {w[WordBits-1:4], inc[3:0]};
      default: next_word = inc;
    endcase
  endfunction

  assign req        = s_cyc & s_stb;
  assign beat_done  = req & (ack_q | err_q);
  assign wr_en      = rstn & ack_q & req & s_we;
  assign baddr_ext  = WordBits'(baddr_q);
  assign baddr_adv  = next_word(baddr_ext, s_bte);
  assign unused_adr = ^s_adr;

`ifdef WB_SRAM_RANGE_ERR_EN
  localparam logic [WordBits-1:0] BaseWord = BASE_ADDR[WB_ADDR_WIDTH-1:Align];
  logic [WordBits-1:0] adr_word, adr_adv;
  assign adr_word = s_adr[WB_ADDR_WIDTH-1:Align];
  // The response is registered, so the following beat's address is checked one cycle early.
  assign adr_adv  = next_word(adr_word, s_bte);
  assign cur_ok   = (adr_word >> MEM_ADDR_BITS) == (BaseWord >> MEM_ADDR_BITS);
  assign nxt_ok   = (adr_adv >> MEM_ADDR_BITS) == (BaseWord >> MEM_ADDR_BITS);
`else
  assign cur_ok = 1'b1;
  assign nxt_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    baddr_d = baddr_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rd_en   = 1'b0;
    rd_addr = baddr_q;
    case (state_q)
      StIdle: begin
        if (req) begin
          baddr_d = s_adr[MEM_ADDR_BITS+Align-1:Align];
          rd_addr = baddr_d;
          state_d = (s_cti == 3'b010) ? StBurst : StClassic;
          ack_d   = cur_ok;
          err_d   = !cur_ok;
          rd_en   = cur_ok;
        end
      end
      StClassic: state_d = StIdle;
      StBurst: begin
        if (!s_cyc) begin
          state_d = StIdle;
        end else if (beat_done) begin
          baddr_d = baddr_adv[MEM_ADDR_BITS-1:0];
          rd_addr = baddr_d;
          if (s_cti == 3'b111) begin
            state_d = StIdle;
          end else begin
            ack_d = nxt_ok;
            err_d = !nxt_ok;
            rd_en = nxt_ok;
          end
        end else if (req) begin
          // Resuming after a wait state: DAT_R already holds this beat's word.
          ack_d = cur_ok;
          err_d = !cur_ok;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StIdle;
      baddr_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_r_q <= '0;
    end else begin
      state_q <= state_d;
      baddr_q <= baddr_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      if (rd_en) dat_r_q <= mem[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < NumBytes; i++) begin
        if (s_sel[i]) mem[baddr_q][8*i +: 8] <= s_dat_w[8*i +: 8];
      end
    end
  end

  assign s_ack   = ack_q;
  assign s_err   = err_q;
  assign s_dat_r = dat_r_q;

endmodule
